// File: rtl/reg_bank_if.sv
// reg_bank_if: op/operand bus between the decoder, the register bank and its read ports.
`timescale 1ns/1ps
interface reg_bank_if #(
    parameter int WIDTH       = 8,
    parameter int NREGS       = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(STACK_DEPTH + 1);
    logic             ena;
    logic [2:0]       opcode;
    logic [AW-1:0]    rd_sel;
    logic [AW-1:0]    rs_sel;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    ra_sel;
    logic [AW-1:0]    rb_sel;
    logic [WIDTH-1:0] ra_out;
    logic [WIDTH-1:0] rb_out;
    logic [SW-1:0]    sp;
    logic             full;
    logic             empty;
    logic             zero;
    logic             err;
    modport master (
        output ena, opcode, rd_sel, rs_sel, data_in, ra_sel, rb_sel,
        input  ra_out, rb_out, sp, full, empty, zero, err
    );
    modport slave (
        input  ena, opcode, rd_sel, rs_sel, data_in, ra_sel, rb_sel,
        output ra_out, rb_out, sp, full, empty, zero, err
    );
endinterface

// File: rtl/reg_bank.sv
// reg_bank: NREGS x WIDTH register file with one register-transfer op per enabled edge
// and a LIFO spill stack; illegal ops pulse err and leave all state untouched.
`timescale 1ns/1ps
module reg_bank #(
    parameter int WIDTH       = 8,
    parameter int NREGS       = 4,
    parameter int STACK_DEPTH = 4
) (
    input logic      clock,
    input logic      reset_n,
    reg_bank_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(STACK_DEPTH + 1);
    localparam int PW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    localparam logic [AW:0]   NR      = (AW + 1)'(NREGS);
    localparam logic [SW-1:0] FULL_SP = SW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_LOAD, OP_MOV, OP_SWAP, OP_INC, OP_DEC, OP_PUSH, OP_POP, OP_CLR
    } op_e;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] stk_q  [STACK_DEPTH];
    logic [WIDTH-1:0] stk_d  [STACK_DEPTH];
    logic [SW-1:0]    sp_q, sp_d;
    logic             zero_q, zero_d, err_q, err_d;
    op_e              op;
    logic             rd_bad, rs_bad, fault, go;
    logic [WIDTH-1:0] rd_val, rs_val, top_val, wr_val;

    assign op = op_e'(bus.opcode);

    assign bus.ra_out = ({1'b0, bus.ra_sel} < NR) ? regs_q[bus.ra_sel] : '0;
    assign bus.rb_out = ({1'b0, bus.rb_sel} < NR) ? regs_q[bus.rb_sel] : '0;
    assign bus.sp     = sp_q;
    assign bus.full   = sp_q == FULL_SP;
    assign bus.empty  = sp_q == '0;
    assign bus.zero   = zero_q;
    assign bus.err    = err_q;

    // Only the selects an opcode actually uses can fault it.
    assign rd_bad = op != OP_PUSH && {1'b0, bus.rd_sel} >= NR;
    assign rs_bad = op inside {OP_MOV, OP_SWAP, OP_PUSH} && {1'b0, bus.rs_sel} >= NR;
    assign fault  = rd_bad || rs_bad || (op == OP_PUSH && bus.full) || (op == OP_POP && bus.empty);
    assign go     = bus.ena && !fault;

    assign rd_val  = regs_q[bus.rd_sel];
    assign rs_val  = regs_q[bus.rs_sel];
    assign top_val = stk_q[PW'(sp_q - 1'b1)];

    always_comb begin
        case (op)
            OP_LOAD:         wr_val = bus.data_in;
            OP_MOV, OP_SWAP: wr_val = rs_val;
            OP_INC:          wr_val = rd_val + 1'b1;
            OP_DEC:          wr_val = rd_val - 1'b1;
            OP_POP:          wr_val = top_val;
            default:         wr_val = '0;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        stk_d  = stk_q;
        sp_d   = sp_q;
        zero_d = zero_q;
        err_d  = bus.ena && fault;
        if (go) begin
            if (op == OP_PUSH) begin
                stk_d[PW'(sp_q)] = rs_val;
                sp_d             = sp_q + 1'b1;
            end else begin
                // rd is written last so SWAP with rd==rs keeps the value.
                if (op == OP_SWAP) regs_d[bus.rs_sel] = rd_val;
                regs_d[bus.rd_sel] = wr_val;
                zero_d             = wr_val == '0;
                if (op == OP_POP) sp_d = sp_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: '0};
            stk_q  <= '{default: '0};
            sp_q   <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            stk_q  <= stk_d;
            sp_q   <= sp_d;
            zero_q <= zero_d;
            err_q  <= err_d;
        end
    end
endmodule
